// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch sequencer: opcode and state
// encodings, the halt word and the branch-offset field width.
package fetch_unit_pkg;

  localparam int INSTR_W  = 9;
  localparam int OPC_W    = 3;
  localparam int BR_OFF_W = 6;

  // Opcode lives in instruction[8:6], operand/offset field in instruction[5:0].
  typedef enum logic [OPC_W-1:0] {
    ADD_OP = 3'd0,
    SUB_OP = 3'd1,
    AND_OP = 3'd2,
    OR_OP  = 3'd3,
    XOR_OP = 3'd4,
    LD_OP  = 3'd5,
    ST_OP  = 3'd6,
    BR_OP  = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  // A branch with a zero offset would spin forever, so it doubles as HALT.
  localparam logic [INSTR_W-1:0] HALT_INSTR = {BR_OP, {BR_OFF_W{1'b0}}};

  function automatic opcode_t get_opcode(input logic [INSTR_W-1:0] instr);
    return opcode_t'(instr[INSTR_W-1 -: OPC_W]);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch sequencer and its environment (start/done
// handshake, instruction memory, datapath branch flag, decoder outputs).
//
// Handshake semantics:
//   start       - one-cycle pulse from the environment; honoured only in IDLE
//                 or HALTED, ignored while a program is running.
//   imem_rd     - read strobe; imem_data carries mem[imem_addr] exactly one
//                 cycle after the cycle imem_rd was high (no back-pressure).
//   init        - low exactly in the cycle an instruction executes; while low,
//                 instruction/pc describe that instruction and br_taken is
//                 sampled at the end of the cycle (BR_OP only).
//   done        - level, high for as long as the sequencer sits in HALTED.
interface fetch_unit_if #(
  parameter int PC_W = 8
);
  import fetch_unit_pkg::*;

  logic                start;
  logic [PC_W-1:0]     imem_addr;
  logic                imem_rd;
  logic [INSTR_W-1:0]  imem_data;
  logic                br_taken;
  logic [INSTR_W-1:0]  instruction;
  logic                init;
  logic [PC_W-1:0]     pc;
  logic                done;

  modport master (
    input  start, imem_data, br_taken,
    output imem_addr, imem_rd, instruction, init, pc, done
  );

  modport slave (
    output start, imem_data, br_taken,
    input  imem_addr, imem_rd, instruction, init, pc, done
  );

endinterface

// File: rtl/fetch_unit_next_pc.sv
// Next-PC rule for the executing instruction: halt holds the pc, a taken
// branch adds the sign-extended 6-bit offset, anything else steps by one.
// All arithmetic wraps modulo 2^PC_W. PC_W must be at least BR_OFF_W.
module fetch_unit_next_pc
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               br_taken,
  output logic [PC_W-1:0]    pc_next,
  output logic               is_halt
);

  logic            is_br;
  logic [PC_W-1:0] off_ext;

  // Decode halt/branch and select the successor address.
  always_comb begin
    is_br   = (get_opcode(instruction) == BR_OP);
    is_halt = (instruction == HALT_INSTR);
    off_ext = {{(PC_W-BR_OFF_W){instruction[BR_OFF_W-1]}},
               instruction[BR_OFF_W-1:0]};
    pc_next = pc + PC_W'(1);
    if (is_halt) begin
      pc_next = pc;
    end else if (is_br && br_taken) begin
      pc_next = pc + off_ext;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: two cycles per instruction (FETCH issues the
// memory read, EXEC presents the returned word to the decoder with init low),
// runs from START_PC until the halt word and then reports done.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus,
  output fetch_state_t  dbg_state
);

  fetch_state_t        state_q, state_d;
  // Address of the next word to fetch (drives imem_addr).
  logic [PC_W-1:0]     fetch_addr_q, fetch_addr_d;
  // Address of the word held in / presented on instruction.
  logic [PC_W-1:0]     pc_q, pc_d;
  // Copy of the last executed word, shown outside EXEC.
  logic [INSTR_W-1:0]  instr_q, instr_d;

  logic [PC_W-1:0]     pc_next;
  logic                is_halt;
  logic                imem_rd;
  logic                init;
  logic                done;
  logic [INSTR_W-1:0]  instr_out;

  fetch_unit_next_pc #(.PC_W(PC_W)) u_next_pc (
    .pc          (pc_q),
    .instruction (bus.imem_data),
    .br_taken    (bus.br_taken),
    .pc_next     (pc_next),
    .is_halt     (is_halt)
  );

  // State, address and instruction registers; reset discards any read in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      pc_q         <= '0;
      instr_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
    end
  end

  // Sequencer next-state and decoder-facing outputs.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    imem_rd      = 1'b0;
    init         = 1'b1;
    done         = 1'b0;
    instr_out    = instr_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          fetch_addr_d = START_PC;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        imem_rd = 1'b1;
        // The word read now is the one executing next cycle.
        pc_d    = fetch_addr_q;
        state_d = EXEC;
      end
      EXEC: begin
        init      = 1'b0;
        // Memory data is only valid this cycle, so bypass it straight out
        // and keep a registered copy for the following cycles.
        instr_out = bus.imem_data;
        instr_d   = bus.imem_data;
        if (is_halt) begin
          state_d = HALTED;
        end else begin
          fetch_addr_d = pc_next;
          state_d      = FETCH;
        end
      end
      HALTED: begin
        done = 1'b1;
        if (bus.start) begin
          fetch_addr_d = START_PC;
          state_d      = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.imem_addr   = fetch_addr_q;
  assign bus.imem_rd     = imem_rd;
  assign bus.init        = init;
  assign bus.done        = done;
  assign bus.pc          = pc_q;
  assign bus.instruction = instr_out;
  assign dbg_state       = state_q;

endmodule
